// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF spike monitor: FSM encoding,
// default widths and thresholds, event buffer geometry and saturating helpers.
package lif_pkg;

    localparam int unsigned DEF_VW     = 16;
    localparam int unsigned DEF_TSW    = 32;
    localparam logic [15:0] DEF_V_TH   = 16'd1000;
    localparam logic [15:0] DEF_V_HYST = 16'd100;

    localparam int unsigned EV_FIFO_DEPTH = 4;
    localparam int unsigned EV_FIFO_AW    = $clog2(EV_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_FIRE     = 2'd1,
        ST_REFRAC   = 2'd2,
        ST_WAIT_LOW = 2'd3
    } lif_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lif_spike_monitor_if.sv
// Spike event stream toward the host: valid/ready handshake carrying the
// timestamp of the event at the head of the buffer.
interface lif_spike_monitor_if
    import lif_pkg::*;
#(
    parameter int unsigned TSW = DEF_TSW
);
    logic           ev_valid;
    logic           ev_ready;
    logic [TSW-1:0] ev_ts;

    modport master (output ev_valid, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_ts, output ev_ready);
endinterface

// File: rtl/lif_event_fifo.sv
// First-word-fall-through timestamp buffer; a push into a full buffer is
// accepted only when a pop frees a slot in the same cycle.
module lif_event_fifo
    import lif_pkg::*;
#(
    parameter int unsigned W = DEF_TSW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = EV_FIFO_AW;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [EV_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(EV_FIFO_DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count define validity, and the head reads as zero when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lif_spike_monitor.sv
// Threshold-crossing spike detector with hysteresis and refractory period,
// timestamped event buffering and a fixed-window firing-rate counter.
module lif_spike_monitor
    import lif_pkg::*;
#(
    parameter int unsigned   VW     = DEF_VW,
    parameter logic [VW-1:0] V_TH   = VW'(DEF_V_TH),
    parameter logic [VW-1:0] V_HYST = VW'(DEF_V_HYST),
    parameter int unsigned   REFRAC = 8,
    parameter int unsigned   WIN    = 100,
    parameter int unsigned   TSW    = DEF_TSW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [VW-1:0]              V_mem,
    input  logic                       V_valid,
    output logic                       spike,
    lif_spike_monitor_if.master        ev,
    output logic [15:0]                rate,
    output logic                       rate_valid,
    output logic [7:0]                 drop_cnt
);
    localparam logic [VW-1:0]  V_REARM  = (V_TH > V_HYST) ? V_TH - V_HYST : '0;
    localparam int unsigned    RCW      = (REFRAC > 1) ? $clog2(REFRAC) : 1;
    localparam int unsigned    WCW      = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [RCW-1:0] RC_LOAD  = RCW'(REFRAC - 1);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);

    lif_state_t     state, state_nxt;
    logic [RCW-1:0] rc_cnt, rc_cnt_nxt;
    logic           fire;
    logic [TSW-1:0] ts;
    logic           ev_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [TSW-1:0] fifo_dout;
    logic [WCW-1:0] win_cnt;
    logic [15:0]    spk_cnt;
    logic [15:0]    spk_sum;
    logic [15:0]    rate_q;
    logic           win_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ARMED;
            rc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rc_cnt <= rc_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        rc_cnt_nxt = rc_cnt;
        fire       = 1'b0;
        case (state)
            ST_ARMED: begin
                if (V_valid && V_mem >= V_TH) state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                fire       = 1'b1;
                rc_cnt_nxt = RC_LOAD;
                state_nxt  = ST_REFRAC;
            end
            ST_REFRAC: begin
                // Leave on the edge where the count would hit zero, so FIRE plus REFRAC spans REFRAC cycles.
                if (rc_cnt <= RCW'(1)) begin
                    state_nxt  = ST_WAIT_LOW;
                    rc_cnt_nxt = '0;
                end else begin
                    rc_cnt_nxt = rc_cnt - RCW'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (V_valid && V_mem < V_REARM) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_ARMED;
        endcase
    end

    assign spike = fire;

    always_ff @(posedge clk) begin
        if (!reset) ts <= '0;
        else        ts <= ts + TSW'(1);
    end

    assign ev_pop = ev.ev_valid && ev.ev_ready;

    lif_event_fifo #(.W(TSW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fire),
        .pop   (ev_pop),
        .din   (ts),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_ts    = fifo_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (fire && fifo_full && !ev_pop) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // The terminal cycle reports the count including a spike in that same cycle.
    assign win_last = (win_cnt == WIN_LAST);
    assign spk_sum  = fire ? sat_inc16(spk_cnt) : spk_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_cnt <= '0;
            spk_cnt <= '0;
            rate_q  <= '0;
        end else if (win_last) begin
            win_cnt <= '0;
            spk_cnt <= '0;
            rate_q  <= spk_sum;
        end else begin
            win_cnt <= win_cnt + WCW'(1);
            spk_cnt <= spk_sum;
        end
    end

    assign rate       = win_last ? spk_sum : rate_q;
    assign rate_valid = win_last;

endmodule
